// File: rtl/ss_pkg.sv
// ---------------------------------------------------------------------------
// ss_pkg: constants and types shared by the systolic-multiplier driver and
// the multiplier side of the serial interface.
//   SS_DW / SS_RW      operand and result widths of the serial protocol
//   N_SMALL / N_LARGE  words per transaction for 2x2 / 4x4
//   R_SMALL / R_LARGE  results per transaction for 2x2 / 4x4
//   state_e            driver FSM states
// ---------------------------------------------------------------------------
package ss_pkg;

  localparam int SS_DW     = 16;
  localparam int SS_RW     = 40;
  localparam int N_SMALL   = 8;
  localparam int N_LARGE   = 32;
  localparam int R_SMALL   = 3;
  localparam int R_LARGE   = 7;
  localparam int RES_DEPTH = R_LARGE;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    COLLECT = 2'd2
  } state_e;

  // Operand words streamed for a given size select.
  function automatic logic [5:0] word_count(input logic size_sel);
    return size_sel ? 6'(N_LARGE) : 6'(N_SMALL);
  endfunction

  // Results expected back for a given size select.
  function automatic logic [2:0] result_count(input logic size_sel);
    return size_sel ? 3'(R_LARGE) : 3'(R_SMALL);
  endfunction

endpackage

// File: rtl/ss_result_buf.sv
// ---------------------------------------------------------------------------
// ss_result_buf: 7 x 40-bit result register file plus fill counter.
//   clk, rst_n  clock, async active-low reset (contents cleared)
//   clr         restart fill at index 0 (contents kept)
//   we, wdata   append wdata at result[count], count++
//   raddr       async read address; addresses >= 7 read as 0
//   rdata       result[raddr]
//   count       number of results written since the last clr
// ---------------------------------------------------------------------------
module ss_result_buf
  import ss_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             we,
  input  logic [SS_RW-1:0] wdata,
  input  logic [2:0]       raddr,
  output logic [SS_RW-1:0] rdata,
  output logic [2:0]       count
);

  logic [SS_RW-1:0] mem [RES_DEPTH];
  logic             wr_ok;

  assign wr_ok = we && (count < 3'(RES_DEPTH));

  // NOTE: the array is built from flops, so it can and must be cleared by
  // reset; a RAM macro could not be, and would need a flush sequence instead.
  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RES_DEPTH; i++) mem[i] <= '0;
      count <= '0;
    end else begin
      if (wr_ok) mem[count] <= wdata;
      if (clr)        count <= '0;
      else if (wr_ok) count <= count + 3'd1;
    end
  end

  assign rdata = (raddr < 3'(RES_DEPTH)) ? mem[raddr] : '0;

endmodule

// File: rtl/ss_driver.sv
// ---------------------------------------------------------------------------
// ss_driver: host-side transmitter/collector for the systolic multiplier.
// The host preloads operand words, pulses start; the block streams N words
// (8 for 2x2, 32 for 4x4) then collects R results (3 or 7) or times out.
//
// Ports
//   clk, rst_n                     clock, async active-low reset
//   load_valid/load_addr/load_data operand buffer write (ignored while busy)
//   start, size_sel                launch (ignored while busy), 0=2x2 1=4x4
//   busy, done, err_timeout        status; err_timeout sticky until next start
//   ss_in_valid/ss_matrix/
//   ss_matrix_size                 registered stream to the multiplier
//   ss_out_valid/ss_out_value      result stream from the multiplier
//   res_addr/res_data/res_count    result readback
//   chk_sum                        sum of captured results (optional)
//
// Optional feature: define SS_DRIVER_CHECKSUM_EN to add the chk_sum port.
// ---------------------------------------------------------------------------
module ss_driver
  import ss_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int DW          = SS_DW,
  parameter int RW          = SS_RW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_valid,
  input  logic [4:0]    load_addr,
  input  logic [DW-1:0] load_data,
  input  logic          start,
  input  logic          size_sel,
  output logic          busy,
  output logic          done,
  output logic          err_timeout,
  output logic          ss_in_valid,
  output logic [DW-1:0] ss_matrix,
  output logic          ss_matrix_size,
  input  logic          ss_out_valid,
  input  logic [RW-1:0] ss_out_value,
  input  logic [2:0]    res_addr,
  output logic [RW-1:0] res_data,
  output logic [2:0]    res_count
`ifdef SS_DRIVER_CHECKSUM_EN
  ,
  output logic [RW+2:0] chk_sum
`endif
);

  localparam int TW = $clog2(TIMEOUT_CYC) + 1;

  state_e        state_q, state_d;
  logic          size_q;
  logic [5:0]    idx_q;          // next buffer address to put on the wire
  logic [TW-1:0] tmo_q;
  logic          done_q, err_q;
  logic [DW-1:0] op_buf [N_LARGE];

  logic          accept, load_en, capture, send_last;
  logic          got_all, tmo_last, finish, finish_tmo;
  logic [DW-1:0] first_word;

  // done_q keeps busy high through the done cycle, so a start coinciding
  // with done is ignored and there is always an idle cycle between bursts.
  assign busy        = (state_q != IDLE) || done_q;
  assign done        = done_q;
  assign err_timeout = err_q;

  assign accept  = start && !busy;
  assign load_en = load_valid && !busy;
  assign capture = (state_q == COLLECT) && ss_out_valid;

  // A load in the start cycle must reach the first word on the wire.
  assign first_word = (load_en && load_addr == 5'd0) ? load_data : op_buf[0];

  // NOTE: every signal assigned in this block gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_d    = state_q;
    send_last  = 1'b0;
    got_all    = 1'b0;
    tmo_last   = 1'b0;
    finish     = 1'b0;
    finish_tmo = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = SEND;
      end
      SEND: begin
        send_last = (idx_q == word_count(size_q));
        if (send_last) state_d = COLLECT;
      end
      COLLECT: begin
        got_all    = capture && (res_count == result_count(size_q) - 3'd1);
        tmo_last   = (tmo_q + TW'(1)) == TW'(TIMEOUT_CYC - 1);
        finish     = got_all || tmo_last;
        finish_tmo = tmo_last && !got_all;
        if (finish) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size_q         <= 1'b0;
      idx_q          <= '0;
      tmo_q          <= '0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      ss_in_valid    <= 1'b0;
      ss_matrix      <= '0;
      ss_matrix_size <= 1'b0;
    end else begin
      done_q <= finish;
      case (state_q)
        IDLE: begin
          if (accept) begin
            size_q         <= size_sel;
            err_q          <= 1'b0;
            idx_q          <= 6'd1;
            ss_in_valid    <= 1'b1;
            ss_matrix      <= first_word;
            ss_matrix_size <= size_sel;
          end
        end
        SEND: begin
          if (send_last) begin
            ss_in_valid    <= 1'b0;
            ss_matrix      <= '0;
            ss_matrix_size <= 1'b0;
            tmo_q          <= '0;
          end else begin
            ss_matrix <= op_buf[idx_q[4:0]];
            idx_q     <= idx_q + 6'd1;
          end
        end
        COLLECT: begin
          tmo_q <= tmo_q + TW'(1);
          if (finish_tmo) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_LARGE; i++) op_buf[i] <= '0;
    end else if (load_en) begin
      op_buf[load_addr] <= load_data;
    end
  end

  ss_result_buf u_result_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .we    (capture),
    .wdata (ss_out_value),
    .raddr (res_addr),
    .rdata (res_data),
    .count (res_count)
  );

`ifdef SS_DRIVER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       chk_sum <= '0;
    else if (accept)  chk_sum <= '0;
    else if (capture) chk_sum <= chk_sum + {3'b000, ss_out_value};
  end
`endif

endmodule

// File: tb/tb_ss_driver.sv
// ---------------------------------------------------------------------------
// tb_ss_driver: self-checking bench for ss_driver. Stimulus tasks drive the
// host and play the multiplier; expected words and completion records go
// into queues that a negedge monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_ss_driver;
  import ss_pkg::*;

  localparam int TIMEOUT_CYC = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_valid;
  logic [4:0]  load_addr;
  logic [15:0] load_data;
  logic        start;
  logic        size_sel;
  logic        busy, done, err_timeout;
  logic        ss_in_valid;
  logic [15:0] ss_matrix;
  logic        ss_matrix_size;
  logic        ss_out_valid;
  logic [39:0] ss_out_value;
  logic [2:0]  res_addr;
  logic [39:0] res_data;
  logic [2:0]  res_count;
`ifdef SS_DRIVER_CHECKSUM_EN
  logic [42:0] chk_sum;
`endif

  ss_driver #(.TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .load_valid     (load_valid),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .start          (start),
    .size_sel       (size_sel),
    .busy           (busy),
    .done           (done),
    .err_timeout    (err_timeout),
    .ss_in_valid    (ss_in_valid),
    .ss_matrix      (ss_matrix),
    .ss_matrix_size (ss_matrix_size),
    .ss_out_valid   (ss_out_valid),
    .ss_out_value   (ss_out_value),
    .res_addr       (res_addr),
    .res_data       (res_data),
    .res_count      (res_count)
`ifdef SS_DRIVER_CHECKSUM_EN
    ,
    .chk_sum        (chk_sum)
`endif
  );

  always #10 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        size;
    logic [15:0] word;
  } word_t;

  typedef struct packed {
    logic [2:0]  cnt;
    logic        err;
    logic [42:0] sum;
  } done_t;

  logic [15:0] mdl_buf [32];
  logic [39:0] mdl_res [7];
  logic [39:0] resp_vals [7];
  word_t       exp_word_q [$];
  done_t       exp_done_q [$];

  function automatic int n_of(input logic sz);
    return sz ? 32 : 8;
  endfunction

  function automatic int r_of(input logic sz);
    return sz ? 7 : 3;
  endfunction

  function automatic logic [39:0] rand40();
    return {8'($urandom), 32'($urandom)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mdl_buf[i] = '0;
    for (int i = 0; i < 7; i++)  mdl_res[i] = '0;
    exp_word_q.delete();
    exp_done_q.delete();
  endtask

  task automatic push_words(input logic sz);
    for (int i = 0; i < n_of(sz); i++) exp_word_q.push_back('{size: sz, word: mdl_buf[i]});
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (ss_in_valid) begin
        if (exp_word_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL stray_word: got 0x%0h with nothing expected", ss_matrix);
        end else begin
          word_t w;
          w = exp_word_q.pop_front();
          check("ss_matrix", 64'(ss_matrix), 64'(w.word));
          check("ss_matrix_size", 64'(ss_matrix_size), 64'(w.size));
        end
      end
      if (done) begin
        if (exp_done_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL stray_done: done pulsed with no transaction expected");
        end else begin
          done_t d;
          d = exp_done_q.pop_front();
          check("done_res_count", 64'(res_count), 64'(d.cnt));
          check("done_err_timeout", 64'(err_timeout), 64'(d.err));
`ifdef SS_DRIVER_CHECKSUM_EN
          check("done_chk_sum", 64'(chk_sum), 64'(d.sum));
`endif
        end
      end
    end
  end

  // ---------------- stimulus tasks (start/end at posedge+1) ----------------
  task automatic load_word(input logic [4:0] a, input logic [15:0] d);
    load_valid = 1'b1;
    load_addr  = a;
    load_data  = d;
    mdl_buf[a] = d;
    @(posedge clk); #1;
    load_valid = 1'b0;
  endtask

  task automatic issue_start(input logic sz, input bit with_load,
                             input logic [4:0] la, input logic [15:0] ld);
    start    = 1'b1;
    size_sel = sz;
    if (with_load) begin
      load_valid  = 1'b1;
      load_addr   = la;
      load_data   = ld;
      mdl_buf[la] = ld;
    end
    push_words(sz);
    @(posedge clk); #1;
    start      = 1'b0;
    load_valid = 1'b0;
  endtask

  // Walks the burst; optionally pokes start/load/out_valid mid-burst.
  task automatic stream(input logic sz, input bit poke, output int unsigned last_cyc);
    last_cyc = 0;
    for (int i = 0; i < n_of(sz); i++) begin
      @(negedge clk);
      check($sformatf("in_valid_w%0d", i), 64'(ss_in_valid), 64'd1);
      if (i == 0) begin
        check("busy_in_send", 64'(busy), 64'd1);
        check("err_cleared_on_start", 64'(err_timeout), 64'd0);
        check("res_count_cleared", 64'(res_count), 64'd0);
      end
      if (poke && i == 3) begin
        start        = 1'b1;
        size_sel     = ~sz;
        load_valid   = 1'b1;
        load_addr    = 5'd0;
        load_data    = 16'hBEEF;
        ss_out_valid = 1'b1;
        ss_out_value = 40'hDE_ADBE_EF00;
      end
      if (poke && i == 4) begin
        start        = 1'b0;
        load_valid   = 1'b0;
        ss_out_valid = 1'b0;
      end
      last_cyc = cyc;
    end
    @(negedge clk);
    check("burst_end_valid", 64'(ss_in_valid), 64'd0);
    check("burst_end_matrix", 64'(ss_matrix), 64'd0);
  endtask

  // Plays the multiplier: returns n_res of resp_vals, then checks completion.
  task automatic respond(input logic sz, input int n_res, input int unsigned last_send,
                         input bit b2b, input logic b2b_sz);
    done_t       d;
    logic [42:0] sum;
    int unsigned cap_cyc;
    int          w;
    bit          full;
    full = (n_res == r_of(sz));
    sum  = '0;
    cap_cyc = 0;
    for (int k = 0; k < n_res; k++) begin
      sum        = sum + 43'(resp_vals[k]);
      mdl_res[k] = resp_vals[k];
    end
    d.cnt = 3'(n_res);
    d.err = !full;
    d.sum = sum;
    exp_done_q.push_back(d);

    @(posedge clk); #1;
    for (int k = 0; k < n_res; k++) begin
      repeat ($urandom_range(0, 2)) begin
        ss_out_value = rand40();
        @(posedge clk); #1;
      end
      ss_out_valid = 1'b1;
      ss_out_value = resp_vals[k];
      cap_cyc      = cyc;
      @(posedge clk); #1;
      ss_out_valid = 1'b0;
    end
    // In the done cycle a stray result pulse must be ignored.
    if (full) begin
      ss_out_valid = 1'b1;
      ss_out_value = rand40();
    end
    if (b2b) begin
      start    = 1'b1;
      size_sel = b2b_sz;
    end

    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!done && w < 300);
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_wait: no done within %0d cycles", w);
    end else if (full) begin
      check("done_latency", 64'(cyc - cap_cyc), 64'd1);
    end else begin
      check("timeout_latency", 64'(cyc - last_send), 64'(TIMEOUT_CYC));
    end
    check("busy_on_done", 64'(busy), 64'd1);

    for (int a = 0; a < 8; a++) begin
      res_addr = 3'(a);
      #1;
      check($sformatf("res_data_%0d", a), 64'(res_data), (a < 7) ? 64'(mdl_res[a]) : 64'd0);
    end

    @(posedge clk); #1;
    ss_out_valid = 1'b0;
    @(negedge clk);
    check("idle_gap_valid", 64'(ss_in_valid), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check("res_count_hold", 64'(res_count), 64'(n_res));
    check("err_sticky", 64'(err_timeout), 64'(!full));
    if (b2b) push_words(b2b_sz);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_txn(input logic sz, input int n_res, input bit with_load,
                         input logic [4:0] la, input logic [15:0] ld);
    int unsigned last;
    issue_start(sz, with_load, la, ld);
    stream(sz, 1'b0, last);
    respond(sz, n_res, last, 1'b0, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int unsigned last;
    logic        sz;
    int          nr;

    rst_n        = 1'b0;
    load_valid   = 1'b0;
    load_addr    = '0;
    load_data    = '0;
    start        = 1'b0;
    size_sel     = 1'b0;
    ss_out_valid = 1'b0;
    ss_out_value = '0;
    res_addr     = '0;
    model_reset();

    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err_timeout), 64'd0);
    check("rst_in_valid", 64'(ss_in_valid), 64'd0);
    check("rst_matrix", 64'(ss_matrix), 64'd0);
    check("rst_res_count", 64'(res_count), 64'd0);
    for (int a = 0; a < 8; a++) begin
      res_addr = 3'(a);
      #1;
      check($sformatf("rst_res_data_%0d", a), 64'(res_data), 64'd0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 2x2 directed
    for (int i = 0; i < 8; i++) load_word(5'(i), 16'(i + 1));
    resp_vals[0] = 40'd10;
    resp_vals[1] = 40'd20;
    resp_vals[2] = 40'd30;
    run_txn(1'b0, 3, 1'b0, 5'd0, 16'd0);

    // 4x4 directed, results near full scale
    for (int i = 0; i < 32; i++) load_word(5'(i), 16'(i + 1));
    for (int k = 0; k < 7; k++) resp_vals[k] = 40'hFF_FFFF_FFFF - 40'(k);
    run_txn(1'b1, 7, 1'b0, 5'd0, 16'd0);

    // Timeout: 2 of 3 results
    resp_vals[0] = 40'h12_3456_789A;
    resp_vals[1] = 40'h00_0000_0001;
    run_txn(1'b0, 2, 1'b0, 5'd0, 16'd0);

    // Busy guards during a 4x4 burst, then back-to-back start into a 2x2
    // that must still see the pre-poke buffer[0].
    issue_start(1'b1, 1'b0, 5'd0, 16'd0);
    stream(1'b1, 1'b1, last);
    for (int k = 0; k < 7; k++) resp_vals[k] = rand40();
    respond(1'b1, 7, last, 1'b1, 1'b0);
    stream(1'b0, 1'b0, last);
    for (int k = 0; k < 3; k++) resp_vals[k] = rand40();
    respond(1'b0, 3, last, 1'b0, 1'b0);

    // Randomized transactions; one has a load in the start cycle.
    for (int it = 0; it < 6; it++) begin
      sz = 1'($urandom_range(0, 1));
      for (int i = 0; i < n_of(sz); i++)
        if ($urandom_range(0, 3) != 0) load_word(5'(i), 16'($urandom));
      nr = ($urandom_range(0, 3) == 0) ? r_of(sz) - 1 : r_of(sz);
      for (int k = 0; k < 7; k++) resp_vals[k] = rand40();
      run_txn(sz, nr, it == 2, 5'($urandom_range(0, n_of(sz) - 1)), 16'($urandom));
    end

    // Asynchronous reset in the middle of a 4x4 burst.
    issue_start(1'b1, 1'b0, 5'd0, 16'd0);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_in_valid", 64'(ss_in_valid), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_res_count", 64'(res_count), 64'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) load_word(5'(i), 16'($urandom));
    for (int k = 0; k < 3; k++) resp_vals[k] = rand40();
    run_txn(1'b0, 3, 1'b0, 5'd0, 16'd0);

    repeat (4) @(posedge clk);
    check("words_drained", 64'(exp_word_q.size()), 64'd0);
    check("dones_drained", 64'(exp_done_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
